// File: rtl/stream_rr_arbiter_if.sv
// Bundled handshake signals between N stream producers and one downstream consumer.
// The arbiter connects through the slave modport, and the producer/consumer side connects through the master modport.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            valid_in;
  logic [NUM_REQ-1:0]            ready_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]            last_in;
  logic                          valid_out;
  logic                          ready_out;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          last_out;
  logic [IDX_W-1:0]              grant_id;
  logic                          err_overflow;

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out, grant_id, err_overflow
  );

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out, grant_id, err_overflow
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// N-to-1 valid/ready stream arbiter with packet-granular round-robin fairness.
// The datapath is combinational with zero latency. Registered state holds the grant lock, the rotation pointer and the beat count.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 256
) (
  input logic               clk,
  input logic               reset,
  stream_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [15:0]      beat_cnt;
  logic             err_q;

  logic [IDX_W-1:0] sel;
  logic             sel_valid;
  logic [IDX_W-1:0] scan_idx;
  logic             xfer;
  logic             sel_last;
  logic             burst_over;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (32'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel       = rr_ptr;
    sel_valid = 1'b0;
    scan_idx  = rr_ptr;
    if (state == LOCKED) begin
      sel       = gnt;
      sel_valid = bus.valid_in[gnt];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!sel_valid && bus.valid_in[scan_idx]) begin
          sel_valid = 1'b1;
          sel       = scan_idx;
        end
        scan_idx = wrap_inc(scan_idx);
      end
    end
  end

  assign sel_last   = bus.last_in[sel];
  assign xfer       = sel_valid && bus.ready_out;
  assign burst_over = ({1'b0, beat_cnt} + 17'd1) >= 17'(MAX_BURST);

  // Reset forces every output quiet, whatever the inputs are doing.
  always_comb begin
    bus.ready_in = '0;
    if (!reset && xfer) bus.ready_in[sel] = 1'b1;
  end

  assign bus.valid_out    = !reset && sel_valid;
  assign bus.data_out     = bus.valid_out ? bus.data_in[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.last_out     = bus.valid_out ? sel_last : 1'b0;
  assign bus.grant_id     = reset ? '0 : sel;
  assign bus.err_overflow = err_q;

  // NOTE: registered state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (xfer) begin
      if (sel_last) begin
        state    <= IDLE;
        rr_ptr   <= wrap_inc(sel);
        beat_cnt <= '0;
      end else begin
        state    <= LOCKED;
        gnt      <= sel;
        beat_cnt <= (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        if (burst_over) err_q <= 1'b1;
      end
    end else if (sel_valid && state == IDLE) begin
      // A stalled offer freezes the grant until that beat is accepted.
      state <= LOCKED;
      gnt   <= sel;
    end
  end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter. It runs directed scenarios and then randomized packet traffic.
// Both phases are checked every cycle against an owner/next-first reference model.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the owner is the requester that holds the output (-1 when free).
  // m_first is where the next free-for-all search begins.
  int m_owner = -1;
  int m_first = 0;
  int m_beats = 0;
  bit m_ovf   = 1'b0;
  int m_acc   = -1;
  int e_sel;
  bit e_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void predict();
    if (m_owner >= 0) begin
      e_sel = m_owner;
      e_v   = bus.valid_in[m_owner];
    end else begin
      e_sel = m_first;
      e_v   = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (bus.valid_in[(m_first + k) % N]) begin
          e_sel = (m_first + k) % N;
          e_v   = 1'b1;
          break;
        end
      end
    end
  endfunction

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    bus.valid_in[i]          = v;
    bus.data_in[i*DW +: DW]  = d;
    bus.last_in[i]           = l;
  endtask

  task automatic clear_all();
    bus.valid_in = '0;
    bus.data_in  = '0;
    bus.last_in  = '0;
  endtask

  task automatic settle();
    @(negedge clk);
    predict();
    if (reset) begin
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_ready_in", bus.ready_in, 0);
      check("rst_grant_id", bus.grant_id, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_last_out", bus.last_out, 0);
    end else begin
      check("valid_out", bus.valid_out, e_v);
      check("ready_in", bus.ready_in, (e_v && bus.ready_out) ? (1 << e_sel) : 0);
      check("grant_id", bus.grant_id, e_sel);
      if (e_v) begin
        check("data_out", bus.data_out, bus.data_in[e_sel*DW +: DW]);
        check("last_out", bus.last_out, bus.last_in[e_sel]);
      end else if (m_owner < 0) begin
        check("idle_data_out", bus.data_out, 0);
        check("idle_last_out", bus.last_out, 0);
      end
    end
    check("err_overflow", bus.err_overflow, m_ovf);
  endtask

  task automatic advance();
    @(posedge clk);
    m_acc = -1;
    if (reset) begin
      m_owner = -1;
      m_first = 0;
      m_beats = 0;
      m_ovf   = 1'b0;
    end else if (e_v && bus.ready_out) begin
      m_acc = e_sel;
      if (bus.last_in[e_sel]) begin
        m_owner = -1;
        m_first = (e_sel + 1) % N;
        m_beats = 0;
      end else begin
        if (m_beats + 1 >= MB) m_ovf = 1'b1;
        m_owner = e_sel;
        if (m_beats < 65535) m_beats++;
      end
    end else if (e_v) begin
      m_owner = e_sel;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  logic [DW-1:0] pa [3];
  int            rem [N];
  logic [DW-1:0] cur [N];

  initial begin
    reset = 1'b1;
    bus.ready_out = 1'b1;
    clear_all();
    @(posedge clk);
    #1;

    // Reset holds outputs quiet even with requests present.
    bus.valid_in = 4'b1011;
    cycle();
    cycle();
    reset = 1'b0;
    clear_all();

    // All requesters valid and every beat single: the grant rotates one per cycle.
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < N; r++) set_req(r, 1'b1, 32'h5000_0000 + 32'(r), 1'b1);
      settle();
      check("rr_seq", bus.grant_id, i % N);
      check("rr_xfer", bus.ready_in, 1 << (i % N));
      advance();
    end
    clear_all();

    // Requester 1 takes a single beat, which moves the rotation to start at 2.
    set_req(1, 1'b1, 32'h11, 1'b1);
    cycle();
    clear_all();

    // A 3-beat packet from requester 2 holds the grant while requester 0 waits.
    pa[0] = 32'hA0; pa[1] = 32'hA1; pa[2] = 32'hA2;
    set_req(0, 1'b1, 32'h00C0_FFEE, 1'b1);
    for (int b = 0; b < 3; b++) begin
      set_req(2, 1'b1, pa[b], b == 2);
      settle();
      check("pkt_grant", bus.grant_id, 2);
      check("pkt_data", bus.data_out, pa[b]);
      advance();
    end
    set_req(2, 1'b0, '0, 1'b0);
    settle();
    check("pkt_next_grant", bus.grant_id, 0);
    advance();
    clear_all();

    // Requester 3 takes a single beat, which moves the rotation to start at 0.
    set_req(3, 1'b1, 32'h33, 1'b1);
    cycle();
    clear_all();
    settle();
    check("idle_ptr", bus.grant_id, 0);
    advance();

    // A stall on requester 1 freezes the grant even after requester 0 raises valid.
    bus.ready_out = 1'b0;
    set_req(1, 1'b1, 32'hB1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, 32'hB0, 1'b1);
      settle();
      check("stall_grant", bus.grant_id, 1);
      check("stall_data", bus.data_out, 32'hB1);
      advance();
    end
    bus.ready_out = 1'b1;
    settle();
    check("stall_release", bus.ready_in, 4'b0010);
    advance();
    set_req(1, 1'b0, '0, 1'b0);
    settle();
    check("stall_next", bus.grant_id, 0);
    advance();
    clear_all();

    // Bubbles from locked requester 3 are not filled by requester 1.
    set_req(3, 1'b1, 32'hC0, 1'b0);
    settle();
    check("bub_grant", bus.grant_id, 3);
    advance();
    set_req(3, 1'b0, '0, 1'b0);
    set_req(1, 1'b1, 32'hD1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("bub_valid", bus.valid_out, 0);
      check("bub_ready", bus.ready_in, 0);
      advance();
    end
    set_req(3, 1'b1, 32'hC1, 1'b0);
    settle();
    check("bub_resume", bus.grant_id, 3);
    advance();
    set_req(3, 1'b1, 32'hC2, 1'b1);
    settle();
    check("bub_last", bus.last_out, 1);
    advance();
    set_req(3, 1'b0, '0, 1'b0);
    settle();
    check("bub_after", bus.grant_id, 1);
    advance();
    clear_all();

    // A 5-beat packet against a 4-beat limit: the flag sets on the 4th transfer and then sticks.
    for (int b = 0; b < 5; b++) begin
      set_req(0, 1'b1, 32'hE0 + 32'(b), b == 4);
      settle();
      check("ovf_grant", bus.grant_id, 0);
      check("ovf_flag", bus.err_overflow, (b >= 4) ? 1 : 0);
      advance();
    end
    clear_all();
    settle();
    check("ovf_sticky", bus.err_overflow, 1);
    advance();

    // Reset in the middle of requester 2's packet: arbitration restarts from index 0.
    set_req(2, 1'b1, 32'hF0, 1'b0);
    settle();
    check("mid_grant", bus.grant_id, 2);
    advance();
    set_req(1, 1'b1, 32'hF1, 1'b1);
    set_req(3, 1'b1, 32'hF3, 1'b1);
    set_req(2, 1'b1, 32'hF2, 1'b0);
    settle();
    check("mid_locked", bus.grant_id, 2);
    advance();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    check("post_rst_grant", bus.grant_id, 1);
    check("post_rst_ovf", bus.err_overflow, 0);
    advance();
    clear_all();

    // Randomized packet traffic with random bubbles, stalls and occasional resets.
    for (int r = 0; r < N; r++) begin
      rem[r] = 0;
      cur[r] = $urandom;
    end
    for (int t = 0; t < 3000; t++) begin
      for (int r = 0; r < N; r++) begin
        if (rem[r] == 0 && $urandom_range(0, 3) == 0) rem[r] = $urandom_range(1, 6);
        set_req(r, (rem[r] != 0) && ($urandom_range(0, 3) != 0), cur[r], rem[r] == 1);
      end
      bus.ready_out = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      if (m_acc >= 0) begin
        rem[m_acc]--;
        cur[m_acc] = $urandom;
      end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
